attack_coord_encoder: RTL and testbench

//   Player-side source of attack coordinates for the battleship board. Samples the row/column

---
 rtl/attack_coord_encoder_if.sv | 20 ++
 rtl/attack_coord_encoder.sv | 129 ++++++++++++
 tb/tb_attack_coord_encoder.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/attack_coord_encoder_if.sv
// Shot-request channel between the attack coordinate encoder (master) and the game core (slave).
// atk_valid/atk_row/atk_col go towards the core; atk_ready and the status strobe come back.
interface attack_coord_encoder_if;
  logic       atk_valid;
  logic       atk_ready;
  logic [2:0] atk_row;
  logic [2:0] atk_col;
  logic       status_vld;
  logic [1:0] status;

  modport master (
    output atk_valid, atk_row, atk_col,
    input  atk_ready, status_vld, status
  );

  modport slave (
    input  atk_valid, atk_row, atk_col,
    output atk_ready, status_vld, status
  );
endinterface

// File: rtl/attack_coord_encoder.sv
// Debounces fire_btn_n, captures row_sw/col_sw on the press and issues one shot; press-to-CHECK is DEBOUNCE_CYCLES+2.
// atk_valid holds until atk_ready, status is taken only while waiting; `REPEAT_CHECK_EN also rejects already-fired cells.
module attack_coord_encoder #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int NUM_ROWS        = 7,
  parameter int NUM_COLS        = 5
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [2:0]            row_sw,
  input  logic [2:0]            col_sw,
  input  logic                  fire_btn_n,
  attack_coord_encoder_if.master atk,
  output logic [1:0]            last_status,
  output logic                  coord_error,
  output logic                  busy,
  output logic [5:0]            shots_fired
);

  localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [3:0]      ROW_LIM  = 4'(NUM_ROWS);
  localparam logic [3:0]      COL_LIM  = 4'(NUM_COLS);

  typedef enum logic [2:0] {IDLE, CHECK, REQ, WAIT, REJECT, RELEASE} state_t;

  state_t           state;
  logic             btn_s1, btn_s2, btn_db;
  logic [CNT_W-1:0] db_cnt;
  logic             db_flip, press_evt;
  logic             atk_valid_q;
  logic [2:0]       atk_row_q, atk_col_q;
  logic             coord_bad, cell_used;

  assign db_flip   = (btn_s2 != btn_db) && (db_cnt == CNT_LAST);
  assign press_evt = db_flip && !btn_db;

  // Button path resets to "pressed" so a button held through reset must be released before it can fire.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      btn_s1 <= 1'b1;
      btn_s2 <= 1'b1;
      btn_db <= 1'b1;
      db_cnt <= '0;
    end else begin
      btn_s1 <= ~fire_btn_n;
      btn_s2 <= btn_s1;
      if ((btn_s2 == btn_db) || db_flip) db_cnt <= '0;
      else                               db_cnt <= db_cnt + 1'b1;
      if (db_flip) btn_db <= ~btn_db;
    end
  end

  assign coord_bad = ({1'b0, atk_row_q} >= ROW_LIM) || ({1'b0, atk_col_q} >= COL_LIM);

`ifdef REPEAT_CHECK_EN
  localparam int CELLS = NUM_ROWS * NUM_COLS;
  localparam int IDX_W = $clog2(CELLS);

  logic [CELLS-1:0] fired_map;
  logic [IDX_W-1:0] cell_idx;

  assign cell_idx  = IDX_W'(atk_row_q) * IDX_W'(NUM_COLS) + IDX_W'(atk_col_q);
  assign cell_used = !coord_bad && fired_map[cell_idx];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                              fired_map           <= '0;
    else if ((state == WAIT) && atk.status_vld) fired_map[cell_idx] <= 1'b1;
  end
`else
  assign cell_used = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      atk_valid_q <= 1'b0;
      atk_row_q   <= '0;
      atk_col_q   <= '0;
      last_status <= '0;
      coord_error <= 1'b0;
      busy        <= 1'b0;
      shots_fired <= '0;
    end else begin
      case (state)
        IDLE: if (press_evt) begin
          atk_row_q <= row_sw;
          atk_col_q <= col_sw;
          busy      <= 1'b1;
          state     <= CHECK;
        end
        CHECK: if (coord_bad || cell_used) begin
          state <= REJECT;
        end else begin
          atk_valid_q <= 1'b1;
          coord_error <= 1'b0;
          state       <= REQ;
        end
        REQ: if (atk.atk_ready) begin
          atk_valid_q <= 1'b0;
          state       <= WAIT;
        end
        WAIT: if (atk.status_vld) begin
          last_status <= atk.status;
          if (shots_fired != 6'd63) shots_fired <= shots_fired + 6'd1;
          state <= RELEASE;
        end
        REJECT: begin
          coord_error <= 1'b1;
          state       <= RELEASE;
        end
        RELEASE: if (!btn_db) begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          atk_valid_q <= 1'b0;
          busy        <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

  assign atk.atk_valid = atk_valid_q;
  assign atk.atk_row   = atk_row_q;
  assign atk.atk_col   = atk_col_q;

endmodule

// File: tb/tb_attack_coord_encoder.sv
// Bench for attack_coord_encoder: directed scenarios with literal expectations, then random presses and
// a random game core, all compared every cycle against a window-based behavioural model.
module tb_attack_coord_encoder;
  localparam int D  = 4;
  localparam int NR = 7;
  localparam int NC = 5;

  logic       clock = 1'b0;
  logic       reset_n = 1'b1;
  logic [2:0] row_sw = '0;
  logic [2:0] col_sw = '0;
  logic       fire_btn_n = 1'b1;
  logic [1:0] last_status;
  logic       coord_error, busy;
  logic [5:0] shots_fired;

  attack_coord_encoder_if atk_if();

  attack_coord_encoder #(.DEBOUNCE_CYCLES(D), .NUM_ROWS(NR), .NUM_COLS(NC)) dut (
    .clock(clock), .reset_n(reset_n), .row_sw(row_sw), .col_sw(col_sw),
    .fire_btn_n(fire_btn_n), .atk(atk_if), .last_status(last_status),
    .coord_error(coord_error), .busy(busy), .shots_fired(shots_fired)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int hs_cnt = 0;
  bit cmp_en = 0;
  bit rand_core = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #2;
    if (rand_core) begin
      atk_if.atk_ready  = ($urandom_range(0, 2) != 0);
      atk_if.status_vld = ($urandom_range(0, 3) == 0);
      atk_if.status     = 2'($urandom_range(0, 3));
    end
  endtask

  // Behavioural model: the debounced level flips once the last D synchronised samples (raw taken
  // two edges earlier) all disagree with it; the shot sequence follows the state rules directly.
  typedef enum {P_IDLE, P_CHECK, P_REQ, P_WAIT, P_REJECT, P_REL} phase_t;
  phase_t     ph;
  bit         hist[$];
  bit         m_db;
  bit         used[NR*NC];
  logic       e_valid, e_err, e_busy;
  logic [2:0] e_row, e_col;
  logic [1:0] e_last;
  int         e_shots;

  always @(posedge clock or negedge reset_n) begin : model
    bit old_db, flip, press_evt;
    if (!reset_n) begin
      hist = {};
      for (int i = 0; i < D + 2; i++) hist.push_back(1'b1);
      m_db = 1'b1; ph = P_IDLE;
      e_valid = 0; e_err = 0; e_busy = 0; e_row = 0; e_col = 0; e_last = 0; e_shots = 0;
      for (int i = 0; i < NR * NC; i++) used[i] = 1'b0;
    end else begin
      old_db = m_db;
      hist.push_back(!fire_btn_n);
      while (hist.size() > D + 2) void'(hist.pop_front());
      flip = 1'b1;
      for (int i = 0; i < D; i++) if (hist[i] == old_db) flip = 1'b0;
      press_evt = flip && !old_db;
      if (flip) m_db = !old_db;
      case (ph)
        P_IDLE: if (press_evt) begin e_row = row_sw; e_col = col_sw; ph = P_CHECK; end
        P_CHECK: begin
          bit bad;
          bad = (int'(e_row) >= NR) || (int'(e_col) >= NC);
`ifdef REPEAT_CHECK_EN
          if (!bad && used[int'(e_row) * NC + int'(e_col)]) bad = 1'b1;
`endif
          if (bad) ph = P_REJECT;
          else begin ph = P_REQ; e_valid = 1; e_err = 0; end
        end
        P_REQ: if (atk_if.atk_ready) begin ph = P_WAIT; e_valid = 0; end
        P_WAIT: if (atk_if.status_vld) begin
          e_last = atk_if.status;
          if (e_shots < 63) e_shots++;
          used[int'(e_row) * NC + int'(e_col)] = 1'b1;
          ph = P_REL;
        end
        P_REJECT: begin e_err = 1; ph = P_REL; end
        P_REL: if (!old_db) ph = P_IDLE;
        default: ph = P_IDLE;
      endcase
      e_busy = (ph != P_IDLE);
    end
  end

  always @(negedge clock) begin
    if (atk_if.atk_valid === 1'b1 && atk_if.atk_ready === 1'b1) hs_cnt++;
    if (cmp_en) begin
      chk("m_atk_valid", 32'(atk_if.atk_valid), 32'(e_valid));
      if (e_valid) begin
        chk("m_atk_row", 32'(atk_if.atk_row), 32'(e_row));
        chk("m_atk_col", 32'(atk_if.atk_col), 32'(e_col));
      end
      chk("m_last_status", 32'(last_status), 32'(e_last));
      chk("m_coord_error", 32'(coord_error), 32'(e_err));
      chk("m_busy", 32'(busy), 32'(e_busy));
      chk("m_shots", 32'(shots_fired), 32'(e_shots));
    end
  end

  task automatic fire_shot(input logic [2:0] r, input logic [2:0] c, input logic [1:0] st, output bit got);
    row_sw = r; col_sw = c; fire_btn_n = 1'b0;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      tick();
      got = atk_if.atk_valid;
    end
    if (got) begin
      atk_if.atk_ready = 1'b1; tick();
      atk_if.atk_ready = 1'b0; atk_if.status_vld = 1'b1; atk_if.status = st; tick();
      atk_if.status_vld = 1'b0;
    end
    fire_btn_n = 1'b1;
    repeat (10) tick();
  endtask

  task automatic try_reject(input string name, input logic [2:0] r, input logic [2:0] c, input int exp_shots);
    int hs0, seen;
    hs0 = hs_cnt; seen = 0;
    row_sw = r; col_sw = c; fire_btn_n = 1'b0;
    repeat (10) begin tick(); if (atk_if.atk_valid) seen++; end
    chk({name, "_err"}, 32'(coord_error), 1);
    fire_btn_n = 1'b1;
    repeat (10) tick();
    chk({name, "_no_req"}, 32'(seen + hs_cnt - hs0), 0);
    chk({name, "_shots"}, 32'(shots_fired), 32'(exp_shots));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int n, hs0;
    bit got1, got2;
    atk_if.atk_ready = 0; atk_if.status_vld = 0; atk_if.status = 0;
    #1;
    reset_n = 0; fire_btn_n = 0; row_sw = 3; col_sw = 2;
    cmp_en = 1;
    repeat (3) tick();
    chk("rst_valid", 32'(atk_if.atk_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_err", 32'(coord_error), 0);
    chk("rst_last", 32'(last_status), 0);
    chk("rst_shots", 32'(shots_fired), 0);
    chk("rst_row", 32'(atk_if.atk_row), 0);
    chk("rst_col", 32'(atk_if.atk_col), 0);
    reset_n = 1;
    n = 0;
    repeat (20) begin tick(); if (busy || atk_if.atk_valid) n++; end
    chk("held_through_reset", 32'(n), 0);
    fire_btn_n = 1; repeat (10) tick();

    // 3-cycle glitch must not fire
    fire_btn_n = 0; repeat (3) tick(); fire_btn_n = 1;
    n = 0;
    repeat (15) begin tick(); if (busy || atk_if.atk_valid) n++; end
    chk("glitch", 32'(n), 0);

    // clean press at (3,2), ready two cycles late, then a hit
    fire_btn_n = 0;
    repeat (6) tick();
    chk("lat_busy", 32'(busy), 1);
    chk("lat_not_yet", 32'(atk_if.atk_valid), 0);
    row_sw = 5; col_sw = 7;
    n = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (atk_if.atk_valid && atk_if.atk_row == 3'd3 && atk_if.atk_col == 3'd2) n++;
      if (i == 2) atk_if.atk_ready = 1;
    end
    chk("req_held_3", 32'(n), 3);
    tick();
    atk_if.atk_ready = 0; atk_if.status_vld = 1; atk_if.status = 2'b10;
    chk("req_dropped", 32'(atk_if.atk_valid), 0);
    tick();
    atk_if.status_vld = 0;
    chk("last_hit", 32'(last_status), 2);
    chk("shots_1", 32'(shots_fired), 1);
    chk("busy_until_release", 32'(busy), 1);
    fire_btn_n = 1; repeat (10) tick();
    chk("idle_after_release", 32'(busy), 0);

    // out-of-range coordinates, then a valid press clears the error
    try_reject("row7", 3'd7, 3'd0, 1);
    try_reject("col5", 3'd0, 3'd5, 1);
    row_sw = 2; col_sw = 4; fire_btn_n = 0;
    got1 = 0;
    for (int i = 0; i < 20 && !got1; i++) begin tick(); got1 = atk_if.atk_valid; end
    chk("valid_after_err", 32'(got1), 1);
    chk("err_cleared", 32'(coord_error), 0);
    atk_if.atk_ready = 1; tick();
    atk_if.atk_ready = 0; atk_if.status_vld = 1; atk_if.status = 2'b01; tick();
    atk_if.status_vld = 0;
    fire_btn_n = 1; repeat (10) tick();
    chk("shots_2", 32'(shots_fired), 2);
    chk("last_water", 32'(last_status), 1);

    // long hold with a second press during WAIT: one request only
    hs0 = hs_cnt;
    row_sw = 0; col_sw = 0; fire_btn_n = 0;
    got1 = 0;
    for (int i = 0; i < 20 && !got1; i++) begin tick(); got1 = atk_if.atk_valid; end
    atk_if.atk_ready = 1; tick(); atk_if.atk_ready = 0;
    fire_btn_n = 1; repeat (8) tick();
    fire_btn_n = 0; repeat (8) tick();
    atk_if.status_vld = 1; atk_if.status = 2'b11; tick(); atk_if.status_vld = 0;
    repeat (100) tick();
    fire_btn_n = 1; repeat (15) tick();
    chk("hold_one_req", 32'(hs_cnt - hs0), 1);
    chk("shots_3", 32'(shots_fired), 3);
    chk("last_sunk", 32'(last_status), 3);

    // same cell twice
    hs0 = hs_cnt;
    fire_shot(3'd1, 3'd1, 2'b01, got1);
    fire_shot(3'd1, 3'd1, 2'b01, got2);
    chk("repeat_first", 32'(got1), 1);
`ifdef REPEAT_CHECK_EN
    chk("repeat_second", 32'(got2), 0);
    chk("repeat_err", 32'(coord_error), 1);
    chk("repeat_hs", 32'(hs_cnt - hs0), 1);
    chk("repeat_shots", 32'(shots_fired), 4);
`else
    chk("repeat_second", 32'(got2), 1);
    chk("repeat_hs", 32'(hs_cnt - hs0), 2);
    chk("repeat_shots", 32'(shots_fired), 5);
`endif

    // random presses, glitches and switch wiggles against a random game core
    rand_core = 1;
    repeat (300) begin
      row_sw = 3'($urandom_range(0, 7));
      col_sw = 3'($urandom_range(0, 7));
      fire_btn_n = 0;
      repeat ($urandom_range(1, 12)) begin
        tick();
        if ($urandom_range(0, 7) == 0) row_sw = 3'($urandom_range(0, 7));
      end
      fire_btn_n = 1;
      repeat ($urandom_range(1, 15)) tick();
    end
    rand_core = 0;
    atk_if.atk_ready = 0; atk_if.status_vld = 0;
    repeat (20) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
